bcd_conv_arbiter: RTL and testbench

Shares a single iterative binary-to-BCD conversion datapath between two requesters: requester 0 is the current reaction time and requester 1 is the best/average time. The block arbitrates round-robin and converts one operand at a time with the add-3-then-shift algorithm, one iteration per clock. Results above 9999 clamp to 9999 with an overflow flag. It sits between the timing/score logic and the 4-digit seven-segment display driver.

---
 rtl/bcd_pkg.sv | 18 +
 rtl/bcd_dabble_step.sv | 24 ++
 rtl/bcd_conv_arbiter.sv | 124 ++++++++++++
 tb/tb_bcd_conv_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared constants and state encoding for the BCD conversion arbiter.
package bcd_pkg;

    localparam int BIN_W   = 14;
    localparam int DIGITS  = 4;
    localparam int BCD_MAX = 9999;

    // Five nibbles so that any 14-bit operand (up to 16383) fits before clamping.
    localparam int ACC_W   = 20;
    localparam int CNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/bcd_dabble_step.sv
// One combinational double-dabble iteration: correct every nibble above 4
// by adding 3, then shift left one place taking in the next operand bit.
module bcd_dabble_step
    import bcd_pkg::*;
(
    input  logic [ACC_W-1:0] acc_i,
    input  logic             bit_i,
    output logic [ACC_W-1:0] acc_o
);

    logic [ACC_W-1:0] adj;

    // Add-3 correction per nibble followed by the shift.
    always_comb begin
        adj = acc_i;
        for (int i = 0; i < ACC_W / 4; i++) begin
            if (acc_i[4*i +: 4] > 4'd4) begin
                adj[4*i +: 4] = acc_i[4*i +: 4] + 4'd3;
            end
        end
        acc_o = {adj[ACC_W-2:0], bit_i};
    end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter in front of a single iterative binary-to-BCD converter.
// Requester 0 is the current reaction time, requester 1 the best/average time.
// Results above 9999 are clamped to 9999 and flagged; latency is fixed at
// BIN_W shift cycles plus one DONE cycle regardless of the operand.
//
// state | meaning
// IDLE  | waiting for a request; grant decided here
// SHIFT | one add-3/shift iteration per clock, BIN_W iterations
// DONE  | result registered, o_valid high for this single cycle
module bcd_conv_arbiter
    import bcd_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    input  logic [BIN_W-1:0]      req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [BIN_W-1:0]      req1_data,
    output logic                  req1_ready,
    output logic                  o_valid,
    output logic                  o_id,
    output logic [4*DIGITS-1:0]   o_bcd,
    output logic                  o_ovf,
    output logic                  busy
);

    localparam logic [BIN_W-1:0]    MAX_BIN = BIN_W'(BCD_MAX);
    localparam logic [CNT_W-1:0]    LAST_IT = CNT_W'(BIN_W - 1);
    localparam logic [4*DIGITS-1:0] CLAMP   = {DIGITS{4'h9}};

    state_e                state_q;
    logic                  last_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [ACC_W-1:0]      acc_q;
    logic [BIN_W-1:0]      opnd_q;
    logic                  id_q;
    logic                  ovf_q;
    logic                  o_valid_q;
    logic                  o_id_q;
    logic [4*DIGITS-1:0]   o_bcd_q;
    logic                  o_ovf_q;

    logic                  grant;
    logic                  hs0;
    logic                  hs1;
    logic [BIN_W-1:0]      opnd_sel;
    logic [ACC_W-1:0]      acc_d;

    bcd_dabble_step u_step (
        .acc_i (acc_q),
        .bit_i (opnd_q[BIN_W-1]),
        .acc_o (acc_d)
    );

    // Grant and ready: on a tie the requester that did not win last time goes.
    always_comb begin
        grant      = (req0_valid && req1_valid) ? ~last_q : req1_valid;
        req0_ready = (state_q == IDLE) && req0_valid && !grant;
        req1_ready = (state_q == IDLE) && req1_valid && grant;
        hs0        = req0_valid && req0_ready;
        hs1        = req1_valid && req1_ready;
        opnd_sel   = hs1 ? req1_data : req0_data;
    end

    // Conversion FSM with capture, iteration and registered result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            id_q      <= 1'b0;
            ovf_q     <= 1'b0;
            o_valid_q <= 1'b0;
            o_id_q    <= 1'b0;
            o_bcd_q   <= '0;
            o_ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    o_valid_q <= 1'b0;
                    if (hs0 || hs1) begin
                        opnd_q  <= opnd_sel;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        id_q    <= hs1;
                        last_q  <= hs1;
                        ovf_q   <= (opnd_sel > MAX_BIN);
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc_q  <= acc_d;
                    opnd_q <= {opnd_q[BIN_W-2:0], 1'b0};
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == LAST_IT) begin
                        state_q   <= DONE;
                        o_valid_q <= 1'b1;
                        o_bcd_q   <= ovf_q ? CLAMP : acc_d[4*DIGITS-1:0];
                        o_id_q    <= id_q;
                        o_ovf_q   <= ovf_q;
                    end
                end
                DONE: begin
                    o_valid_q <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    o_valid_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign o_valid = o_valid_q;
    assign o_id    = o_id_q;
    assign o_bcd   = o_bcd_q;
    assign o_ovf   = o_ovf_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Bench for bcd_conv_arbiter: directed scenarios followed by random traffic,
// checked each cycle against a transaction-level model of the converter.
module tb_bcd_conv_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [13:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        o_valid, o_id, o_ovf, busy;
    logic [15:0] o_bcd;

    bcd_conv_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .o_valid    (o_valid),
        .o_id       (o_id),
        .o_bcd      (o_bcd),
        .o_ovf      (o_ovf),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // model state: one conversion in flight at most
    int          n         = 0;
    int          next_free = 0;
    int          done_cyc  = -1;
    int          last_g    = 1;
    logic [15:0] pend_bcd  = '0;
    logic        pend_id   = 1'b0;
    logic        pend_ovf  = 1'b0;
    logic [15:0] held_bcd  = '0;
    logic        held_id   = 1'b0;
    logic        held_ovf  = 1'b0;

    // requester behaviour
    bit          pend0 = 0, pend1 = 0;
    logic [13:0] dat0 = '0, dat1 = '0;
    int          q0[$];
    int          q1[$];
    bit          rnd_mode = 0;
    bit          rearm    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, n);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int x);
        int v;
        v = (x > 9999) ? 9999 : x;
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [13:0] rand_opnd();
        case ($urandom_range(0, 5))
            0:       return 14'd0;
            1:       return 14'd9999;
            2:       return 14'd10000;
            3:       return 14'd16383;
            4:       return 14'($urandom_range(0, 9999));
            default: return 14'($urandom_range(0, 16383));
        endcase
    endfunction

    task automatic step();
        bit idle, e0, e1;
        int g;
        int d;
        @(negedge clk);
        n++;
        chk("o_valid", o_valid, n == done_cyc);
        chk("busy", busy, n < next_free);
        if (n == done_cyc) begin
            held_bcd = pend_bcd;
            held_id  = pend_id;
            held_ovf = pend_ovf;
        end
        chk("o_bcd", o_bcd, held_bcd);
        chk("o_id", o_id, held_id);
        chk("o_ovf", o_ovf, held_ovf);

        if (!pend0) begin
            if (q0.size() > 0) begin
                pend0 = 1; dat0 = 14'(q0.pop_front());
            end else if (rearm || (rnd_mode && $urandom_range(0, 3) == 0)) begin
                pend0 = 1; dat0 = rand_opnd();
            end
        end
        if (!pend1) begin
            if (q1.size() > 0) begin
                pend1 = 1; dat1 = 14'(q1.pop_front());
            end else if (rearm || (rnd_mode && $urandom_range(0, 3) == 0)) begin
                pend1 = 1; dat1 = rand_opnd();
            end
        end
        req0_valid = pend0;
        req0_data  = pend0 ? dat0 : 14'($urandom);
        req1_valid = pend1;
        req1_data  = pend1 ? dat1 : 14'($urandom);
        #1;
        idle = (n >= next_free);
        if (pend0 && pend1) g = 1 - last_g;
        else                g = pend1 ? 1 : 0;
        e0 = idle && pend0 && (g == 0);
        e1 = idle && pend1 && (g == 1);
        chk("req0_ready", req0_ready, e0);
        chk("req1_ready", req1_ready, e1);
        if (e0 || e1) begin
            d         = e1 ? int'(dat1) : int'(dat0);
            pend_bcd  = to_bcd(d);
            pend_ovf  = (d > 9999);
            pend_id   = e1;
            last_g    = g;
            done_cyc  = n + 15;
            next_free = n + 16;
            if (e1) pend1 = 0;
            else    pend0 = 0;
        end
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step();
    endtask

    // asynchronous reset pulse, applied away from the clock edges
    task automatic pulse_reset();
        rst        = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        chk("rst_o_valid", o_valid, 0);
        chk("rst_o_bcd", o_bcd, 0);
        chk("rst_o_id", o_id, 0);
        chk("rst_o_ovf", o_ovf, 0);
        chk("rst_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst       = 1'b0;
        next_free = 0;
        done_cyc  = -1;
        last_g    = 1;
        held_bcd  = '0;
        held_id   = 1'b0;
        held_ovf  = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_data  = '0;
        req1_data  = '0;
        #1;
        chk("init_o_valid", o_valid, 0);
        chk("init_o_bcd", o_bcd, 0);
        chk("init_busy", busy, 0);
        chk("init_req0_ready", req0_ready, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        q0.push_back(1234);
        run(20);

        q0.push_back(0);
        q1.push_back(9999);
        run(35);

        q1.push_back(16383);
        run(20);

        rearm = 1;
        run(62);
        rearm = 0;
        run(40);

        q0.push_back(5000);
        run(1);
        while (n < next_free - 16 + 8) step();
        pulse_reset();
        run(25);

        q0.push_back(42);
        run(20);

        q0.push_back(9999);
        q0.push_back(10000);
        run(40);

        rnd_mode = 1;
        run(2000);
        rnd_mode = 0;
        run(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
